// File: rtl/sort_pkg.sv
// Shared constants and FSM state encoding for the odd-even transposition sort engine.
package sort_pkg;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);
    // One extra bit so the counter can hold DEPTH itself during the READ tail cycle.
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SORT,
        S_WRITE,
        S_DONE
    } state_t;
endpackage

// File: rtl/sort_if.sv
// ROM read / RAM write / done bundle between the sort engine (master) and its memories (slave).
interface sort_if;
    import sort_pkg::*;

    logic              IROM_rd;
    logic [ADDR_W-1:0] IROM_A;
    logic [DATA_W-1:0] IROM_Q;
    logic              IRAM_valid;
    logic [ADDR_W-1:0] IRAM_A;
    logic [DATA_W-1:0] IRAM_D;
    logic              done;

    modport master (
        output IROM_rd, IROM_A,
        input  IROM_Q,
        output IRAM_valid, IRAM_A, IRAM_D, done
    );

    modport slave (
        input  IROM_rd, IROM_A,
        output IROM_Q,
        input  IRAM_valid, IRAM_A, IRAM_D, done
    );
endinterface

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange cell; lo feeds the lower buffer index.
// Ordering is ascending by default, descending when SORT_DESCENDING_EN is defined.
module sort_cmp_swap
    import sort_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);
    logic swap;

    // Strict compare so equal values never move.
`ifdef SORT_DESCENDING_EN
    assign swap = (a < b);
`else
    assign swap = (a > b);
`endif

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;
endmodule

// File: rtl/sort.sv
// Sort engine: loads DEPTH bytes from IROM, runs DEPTH odd-even transposition phases,
// writes the result to IRAM and raises a sticky done. SORT_DESCENDING_EN flips the order.
module sort
    import sort_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    sort_if.master  bus
);
    state_t                       state_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [CNT_W-1:0]             cnt_inc;
    logic [DEPTH-1:0][DATA_W-1:0] data_reg;
    logic [DEPTH-1:0][DATA_W-1:0] even_next;
    logic [DEPTH-1:0][DATA_W-1:0] odd_next;
    logic [DEPTH-1:0][DATA_W-1:0] phase_next;

    logic              rom_rd_reg;
    logic [ADDR_W-1:0] rom_a_reg;
    logic              ram_valid_reg;
    logic [ADDR_W-1:0] ram_a_reg;
    logic [DATA_W-1:0] ram_d_reg;
    logic              done_reg;

    assign cnt_inc = cnt_reg + CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH / 2; gi++) begin : g_even
            sort_cmp_swap u_cs (
                .a  (data_reg[2*gi]),
                .b  (data_reg[2*gi+1]),
                .lo (even_next[2*gi]),
                .hi (even_next[2*gi+1])
            );
        end
        for (gi = 0; gi < DEPTH / 2 - 1; gi++) begin : g_odd
            sort_cmp_swap u_cs (
                .a  (data_reg[2*gi+1]),
                .b  (data_reg[2*gi+2]),
                .lo (odd_next[2*gi+1]),
                .hi (odd_next[2*gi+2])
            );
        end
    endgenerate

    // End elements have no partner in the odd phase.
    assign odd_next[0]       = data_reg[0];
    assign odd_next[DEPTH-1] = data_reg[DEPTH-1];
    assign phase_next        = cnt_reg[0] ? odd_next : even_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            data_reg      <= '0;
            rom_rd_reg    <= 1'b0;
            rom_a_reg     <= '0;
            ram_valid_reg <= 1'b0;
            ram_a_reg     <= '0;
            ram_d_reg     <= '0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg  <= S_READ;
                    cnt_reg    <= '0;
                    rom_rd_reg <= 1'b1;
                    rom_a_reg  <= '0;
                end
                S_READ: begin
                    // ROM data for address cnt arrives one cycle after it was presented.
                    if (cnt_reg == CNT_W'(DEPTH)) begin
                        state_reg <= S_SORT;
                        cnt_reg   <= '0;
                    end else begin
                        data_reg[cnt_reg[ADDR_W-1:0]] <= bus.IROM_Q;
                        cnt_reg <= cnt_inc;
                        if (cnt_inc == CNT_W'(DEPTH)) begin
                            rom_rd_reg <= 1'b0;
                            rom_a_reg  <= '0;
                        end else begin
                            rom_a_reg  <= cnt_inc[ADDR_W-1:0];
                        end
                    end
                end
                S_SORT: begin
                    data_reg <= phase_next;
                    if (cnt_reg == CNT_W'(DEPTH - 1)) begin
                        // First write word comes straight from the final phase result.
                        state_reg     <= S_WRITE;
                        cnt_reg       <= '0;
                        ram_valid_reg <= 1'b1;
                        ram_a_reg     <= '0;
                        ram_d_reg     <= phase_next[0];
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                S_WRITE: begin
                    if (cnt_reg == CNT_W'(DEPTH - 1)) begin
                        state_reg     <= S_DONE;
                        ram_valid_reg <= 1'b0;
                        ram_a_reg     <= '0;
                        ram_d_reg     <= '0;
                        done_reg      <= 1'b1;
                    end else begin
                        cnt_reg   <= cnt_inc;
                        ram_a_reg <= cnt_inc[ADDR_W-1:0];
                        ram_d_reg <= data_reg[cnt_inc[ADDR_W-1:0]];
                    end
                end
                S_DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.IROM_rd    = rom_rd_reg;
    assign bus.IROM_A     = rom_a_reg;
    assign bus.IRAM_valid = ram_valid_reg;
    assign bus.IRAM_A     = ram_a_reg;
    assign bus.IRAM_D     = ram_d_reg;
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_sort.sv
// Table-driven bench for the sort engine: ROM/RAM models on the falling edge,
// directed vectors, done-latency and protocol checks, plus a mid-SORT reset abort.
`timescale 1ns/1ps
module tb_sort;
    import sort_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sort_if bus();

    sort dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef SORT_DESCENDING_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    typedef struct packed {
        logic [15:0][7:0] rom;
        logic [15:0][7:0] exp;
    } vec_t;

    vec_t vecs [5];

    logic [7:0] rom_mem [16];
    logic [7:0] ram_mem [16];
    logic [7:0] rom_q = 8'h00;
    assign bus.IROM_Q = rom_q;

    int checks = 0;
    int failures = 0;
    int rd_cycles, wr_cycles, proto_err;
    int addr_hits [16];
    bit done_seen;

    // Memory models and protocol monitor, all on the falling edge.
    always @(negedge clk) begin
        if (bus.IROM_rd) rom_q <= rom_mem[bus.IROM_A];
        if (bus.IRAM_valid) ram_mem[bus.IRAM_A] = bus.IRAM_D;
        if (reset) begin
            if (bus.IROM_rd) rd_cycles++;
            if (bus.IRAM_valid) begin
                wr_cycles++;
                addr_hits[bus.IRAM_A]++;
            end
            if (bus.IROM_rd && (bus.IRAM_valid || bus.done)) proto_err++;
            if (done_seen && !bus.done) proto_err++;
            if (bus.done) done_seen = 1'b1;
        end
    end

    function automatic logic [15:0][7:0] mk(input logic [127:0] lit);
        logic [15:0][7:0] r;
        for (int i = 0; i < 16; i++) r[i] = lit[127-8*i -: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clear_mon();
        rd_cycles = 0;
        wr_cycles = 0;
        proto_err = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr_hits[i] = 0;
            ram_mem[i] = 8'hA5;
        end
    endtask

    function automatic logic [31:0] outs_word();
        return {19'd0, bus.IROM_rd, bus.IROM_A, bus.IRAM_valid, bus.IRAM_A, bus.IRAM_D, bus.done};
    endfunction

    task automatic run_vec(input int idx, input int abort_edge);
        int bad_addr;
        logic [7:0] req;
        for (int i = 0; i < 16; i++) rom_mem[i] = vecs[idx].rom[i];
        reset = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        if (abort_edge > 0) begin
            repeat (abort_edge) @(posedge clk);
            #1 reset = 1'b0;
            #1 chk("abort_outputs_zero", outs_word(), 32'd0);
            repeat (3) @(posedge clk);
            #1 chk("abort_hold_zero", outs_word(), 32'd0);
            clear_mon();
            @(negedge clk);
            reset = 1'b1;
        end
        for (int e = 1; e <= 52; e++) begin
            @(posedge clk);
            #1;
            if (e == 49) chk("done_not_before_50", {31'd0, bus.done}, 32'd0);
            if (e == 50) chk("done_at_50", {31'd0, bus.done}, 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            req = DESC ? vecs[idx].exp[15-i] : vecs[idx].exp[i];
            chk($sformatf("ram[%0d]", i), {24'd0, ram_mem[i]}, {24'd0, req});
        end
        bad_addr = 0;
        for (int i = 0; i < 16; i++) if (addr_hits[i] != 1) bad_addr++;
        chk("rom_rd_cycles", rd_cycles, 32'd16);
        chk("ram_valid_cycles", wr_cycles, 32'd16);
        chk("ram_addr_once", bad_addr, 32'd0);
        chk("protocol_errors", proto_err, 32'd0);
        $display("vector %0d abort_edge=%0d ram0=%02h ram15=%02h done=%0b", idx, abort_edge,
                 ram_mem[0], ram_mem[15], bus.done);
    endtask

    initial begin
        vecs[0].rom = mk(128'h0F0E0D0C0B0A09080706050403020100);
        vecs[0].exp = mk(128'h000102030405060708090A0B0C0D0E0F);
        vecs[1].rom = mk(128'h5A13FF5A00C35A2780017E13FE449B02);
        vecs[1].exp = mk(128'h000102131327445A5A5A7E809BC3FEFF);
        vecs[2].rom = mk(128'h77777777777777777777777777777777);
        vecs[2].exp = mk(128'h77777777777777777777777777777777);
        vecs[3].rom = mk(128'h030810112_02F4055607F80A0B5C0E1FE);
        vecs[3].exp = mk(128'h030810112_02F4055607F80A0B5C0E1FE);
        vecs[4].rom = mk(128'h000102030405060708090A0B0C0D0E0F);
        vecs[4].exp = mk(128'h000102030405060708090A0B0C0D0E0F);

        clear_mon();
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs_zero", outs_word(), 32'd0);

        for (int v = 0; v < 5; v++) run_vec(v, 0);

        // Reset lands mid-SORT (edges 19..34 are sort phases), then a clean full re-run.
        run_vec(1, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
